lsu_m2: RTL and testbench

Parametrised successor load/store unit for the M-series execute stage. It captures load, store and fence requests into an input register, buffers them in a DEPTH-entry circular LSQ, and issues them in order through a registered valid/ready port to the memory & IO controller. New versus the previous generation:
- configurable data/address width and queue depth;
- a bounded outstanding-load counter;
- fence draining, where a fence is held until all prior loads have completed and memory is idle;
- a proper valid/ready memory handshake.

---
 rtl/lsu_m2.sv | 117 +++++++++++
 tb/tb_lsu_m2.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_m2.sv
// lsu_m2: load/store unit with input stage, circular LSQ, bounded outstanding loads,
// fence draining and a registered valid/ready issue port to the memory controller.
module lsu_m2 #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 4,
  parameter int DEST_W  = 4
) (
  input  logic                                  clk,
  input  logic                                  async_rst,
  input  logic                                  clk_en,
  input  logic                                  call,
  input  logic [3:0]                            func4_in,
  input  logic                                  fence_mode,
  input  logic [1:0]                            fence_type,
  input  logic [DEST_W-1:0]                     dest_addr_in,
  input  logic [ADDR_W-1:0]                     address_in,
  input  logic [DATA_W-1:0]                     store_data_in,
  output logic                                  lsq_full,
  output logic                                  lsu_empty,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_address_out,
  output logic [DATA_W/8-1:0]                   mem_mask_out,
  output logic [1:0]                            mem_fnc_type,
  output logic [DATA_W-1:0]                     mem_data_out,
  output logic [1:0]                            mem_mode,
  output logic [DEST_W-1:0]                     mem_wb_dest,
  output logic                                  mem_enable,
  input  logic                                  mem_ready,
  input  logic                                  mem_read_ack,
  input  logic [DATA_W-1:0]                     mem_data_in,
  input  logic [DEST_W-1:0]                     mem_wb_dest_in,
  input  logic                                  mem_idle,
  output logic                                  wb_valid,
  output logic [DATA_W-1:0]                     wb_data_out,
  output logic [DEST_W-1:0]                     wb_dest_addr_out
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB = $clog2(BYTES);
  localparam int AW = ADDR_W - LB;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  typedef struct packed {
    logic [1:0]        mode;
    logic [1:0]        fnc;
    logic [AW-1:0]     addr;
    logic [BYTES-1:0]  mask;
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } req_t;
  req_t in_r, s1, hd, is;
  req_t q [DEPTH];
  logic s1_valid, push, pop, xfer, gate, rd_ok, fn_ok, inc, dec, unused;
  logic [PW:0] head, tail, count, count_n;
  logic [OW-1:0] outst;
  assign unused = func4_in[1];
  always_comb begin
    in_r.mode = {fence_mode, !fence_mode && func4_in[3]};
    in_r.fnc = fence_mode ? fence_type : {func4_in[2], func4_in[0]};
    in_r.addr = address_in[ADDR_W-1:LB];
    in_r.dest = dest_addr_in;
    in_r.mask = '0;
    in_r.data = '0;
    for (int i = 0; i < BYTES; i++) begin
      in_r.mask[BYTES-1-i] = func4_in[0] || address_in[LB-1:0] == LB'(i);
      in_r.data[8*(BYTES-1-i)+:8] = func4_in[0] ? store_data_in[8*i+:8] : store_data_in[7:0];
    end
  end
  assign hd = q[head[PW-1:0]];
  assign xfer = mem_enable && mem_ready;
  assign inc = xfer && is.mode == 2'd0;
  assign dec = mem_read_ack && (outst != '0 || inc);
  // a read sitting in the issue register already counts against the load budget
  assign rd_ok = {1'b0, outst} + (OW+1)'(mem_enable && is.mode == 2'd0) < (OW+1)'(MAX_OUT);
  assign fn_ok = (!mem_enable || (xfer && is.mode == 2'd1)) && outst == '0 && mem_idle;
  assign gate = hd.mode[1] ? fn_ok : (hd.mode[0] || rd_ok);
  assign push = clk_en && s1_valid && count != (PW+1)'(DEPTH);
  assign pop = clk_en && count != '0 && (!mem_enable || mem_ready) && gate;
  assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      s1_valid <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
      lsq_full <= 1'b0;
      outst <= '0;
      mem_enable <= 1'b0;
      is <= '0;
    end else if (clk_en) begin
      if (!lsq_full) s1_valid <= call;
      if (push) tail <= tail + (PW+1)'(1);
      if (pop) head <= head + (PW+1)'(1);
      count <= count_n;
      lsq_full <= count_n == (PW+1)'(DEPTH);
      outst <= outst + OW'(inc) - OW'(dec);
      if (pop) begin
        mem_enable <= 1'b1;
        is <= hd;
      end else if (xfer) mem_enable <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (clk_en && !lsq_full) s1 <= in_r;
    if (push) q[tail[PW-1:0]] <= s1;
  end
  assign mem_mode = is.mode;
  assign mem_fnc_type = is.fnc;
  assign mem_address_out = is.addr;
  assign mem_mask_out = is.mask;
  assign mem_data_out = is.data;
  assign mem_wb_dest = is.dest;
  assign lsu_empty = !s1_valid && count == '0 && !mem_enable && outst == '0 && mem_idle;
  assign wb_valid = mem_read_ack;
  assign wb_data_out = mem_data_in;
  assign wb_dest_addr_out = mem_wb_dest_in;
endmodule

// File: tb/tb_lsu_m2.sv
// tb_lsu_m2: directed scenarios plus randomized traffic against an in-order request model.
module tb_lsu_m2;
  localparam int MAX_OUT = 4;
  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  fnc;
    logic [14:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
    logic [3:0]  dest;
  } req_t;
  logic clk = 0, async_rst = 1, call = 0, fence_mode = 0;
  logic [3:0] func4_in = 0, dest_addr_in = 0, mem_wb_dest_in = 0;
  logic [1:0] fence_type = 0;
  logic [15:0] address_in = 0, store_data_in = 0, mem_data_in = 0;
  logic lsq_full, lsu_empty, mem_enable, wb_valid;
  logic [14:0] mem_address_out;
  logic [1:0] mem_mask_out, mem_fnc_type, mem_mode;
  logic [15:0] mem_data_out, wb_data_out;
  logic [3:0] mem_wb_dest, wb_dest_addr_out;
  logic mem_ready, mem_read_ack, mem_idle, clk_en;
  logic d_ready = 1, d_idle = 1, d_ack = 0, d_en = 1;
  logic r_ready = 1, r_idle = 1, r_ack = 0, r_en = 1, rnd_on = 0;
  int tests = 0, fails = 0, n_xfer = 0, m_out = 0;
  req_t exp_q[$];
  logic hold = 0;
  logic [40:0] prev_pl = 0;

  assign mem_ready = rnd_on ? r_ready : d_ready;
  assign mem_idle = rnd_on ? r_idle : d_idle;
  assign mem_read_ack = rnd_on ? r_ack : d_ack;
  assign clk_en = rnd_on ? r_en : d_en;

  lsu_m2 #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .MAX_OUT(MAX_OUT), .DEST_W(4)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .call(call), .func4_in(func4_in),
    .fence_mode(fence_mode), .fence_type(fence_type), .dest_addr_in(dest_addr_in),
    .address_in(address_in), .store_data_in(store_data_in), .lsq_full(lsq_full),
    .lsu_empty(lsu_empty), .mem_address_out(mem_address_out), .mem_mask_out(mem_mask_out),
    .mem_fnc_type(mem_fnc_type), .mem_data_out(mem_data_out), .mem_mode(mem_mode),
    .mem_wb_dest(mem_wb_dest), .mem_enable(mem_enable), .mem_ready(mem_ready),
    .mem_read_ack(mem_read_ack), .mem_data_in(mem_data_in), .mem_wb_dest_in(mem_wb_dest_in),
    .mem_idle(mem_idle), .wb_valid(wb_valid), .wb_data_out(wb_data_out),
    .wb_dest_addr_out(wb_dest_addr_out));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Expected issue payload derived directly from the request encoding rules
  function automatic req_t enc(input logic fm, input logic [1:0] ft, input logic [3:0] f4,
                               input logic [3:0] dst, input logic [15:0] a, input logic [15:0] d);
    req_t r;
    r.mode = fm ? 2'd2 : (f4[3] ? 2'd1 : 2'd0);
    r.fnc = fm ? ft : {f4[2], f4[0]};
    r.addr = a[15:1];
    r.mask = f4[0] ? 2'b11 : (a[0] ? 2'b01 : 2'b10);
    r.data = f4[0] ? {d[7:0], d[15:8]} : {d[7:0], d[7:0]};
    r.dest = dst;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic fm, input logic [1:0] ft, input logic [3:0] f4,
                      input logic [3:0] dst, input logic [15:0] a, input logic [15:0] d);
    logic acc;
    call = 1; fence_mode = fm; fence_type = ft; func4_in = f4;
    dest_addr_in = dst; address_in = a; store_data_in = d;
    for (int i = 0; i < 400; i++) begin
      acc = !lsq_full && clk_en;
      tick();
      if (acc) begin
        call = 0;
        return;
      end
    end
    call = 0;
    timeout("send");
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (lsu_empty && exp_q.size() == 0) return;
      tick();
    end
    timeout("drain");
  endtask

  task automatic wait_en();
    for (int i = 0; i < 20; i++) begin
      if (mem_enable) return;
      tick();
    end
    timeout("mem_enable");
  endtask

  always begin
    @(posedge clk);
    #1;
    mem_data_in = 16'($urandom);
    mem_wb_dest_in = 4'($urandom);
    r_ready = $urandom_range(0, 3) != 0;
    r_idle = $urandom_range(0, 4) != 0;
    r_ack = (m_out > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 40) == 0;
    r_en = $urandom_range(0, 15) != 0;
  end

  always @(negedge clk) begin
    logic [40:0] pl;
    logic rd;
    req_t e;
    chk("wb_valid", wb_valid, mem_read_ack);
    chk("wb_data", wb_data_out, mem_data_in);
    chk("wb_dest", wb_dest_addr_out, mem_wb_dest_in);
    if (async_rst) begin
      chk("rst_enable", mem_enable, 0);
      chk("rst_full", lsq_full, 0);
      chk("rst_empty", lsu_empty, mem_idle);
      exp_q.delete();
      m_out = 0;
      hold = 0;
    end else begin
      chk("lsu_empty", lsu_empty, exp_q.size() == 0 && m_out == 0 && mem_idle);
      pl = {mem_mode, mem_fnc_type, mem_address_out, mem_mask_out, mem_data_out, mem_wb_dest};
      if (hold) begin
        chk("hold_enable", mem_enable, 1);
        chk("hold_payload", pl, prev_pl);
      end
      if (clk_en) begin
        rd = 0;
        if (mem_enable && mem_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) timeout("xfer_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("x_mode", mem_mode, e.mode);
            chk("x_fnc", mem_fnc_type, e.fnc);
            chk("x_addr", mem_address_out, e.addr);
            chk("x_mask", mem_mask_out, e.mask);
            if (e.mode == 2'd1) chk("x_data", mem_data_out, e.data);
            if (e.mode == 2'd0) begin
              chk("x_dest", mem_wb_dest, e.dest);
              chk("x_max_out", m_out < MAX_OUT, 1);
              rd = 1;
            end
            if (e.mode[1]) chk("x_fence_drained", m_out, 0);
          end
        end
        if (rd && !mem_read_ack) m_out++;
        else if (!rd && mem_read_ack && m_out > 0) m_out--;
        if (call && !lsq_full)
          exp_q.push_back(enc(fence_mode, fence_type, func4_in, dest_addr_in, address_in, store_data_in));
      end
      hold = mem_enable && !(mem_ready && clk_en);
      prev_pl = pl;
    end
  end

  initial begin
    int x0, k;
    logic [14:0] snap_a;
    logic snap_en, snap_full, snap_empty;
    logic [3:0] f;
    tick(); tick();
    chk("rst_mode", mem_mode, 0);
    chk("rst_addr", mem_address_out, 0);
    chk("rst_mask", mem_mask_out, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_dest", mem_wb_dest, 0);
    chk("rst_fnc", mem_fnc_type, 0);
    d_idle = 0; #1;
    chk("rst_empty_idle0", lsu_empty, 0);
    d_idle = 1; #1;
    chk("rst_empty_idle1", lsu_empty, 1);
    async_rst = 0;
    tick();
    // byte load then word store, back to back
    send(0, 0, 4'b0000, 4'd1, 16'h0003, 16'h0);
    send(0, 0, 4'b1001, 4'd0, 16'h0004, 16'hA1B2);
    wait_en();
    chk("t1_rd_mode", mem_mode, 0);
    chk("t1_rd_addr", mem_address_out, 15'h0001);
    chk("t1_rd_mask", mem_mask_out, 2'b01);
    chk("t1_rd_fnc", mem_fnc_type, 2'b00);
    tick();
    chk("t1_wr_en", mem_enable, 1);
    chk("t1_wr_mode", mem_mode, 1);
    chk("t1_wr_addr", mem_address_out, 15'h0002);
    chk("t1_wr_mask", mem_mask_out, 2'b11);
    chk("t1_wr_data", mem_data_out, 16'hB2A1);
    d_ack = 1; tick(); d_ack = 0;
    wait_empty(50);
    // fill the queue with memory stalled
    d_ready = 0;
    x0 = n_xfer;
    for (int i = 0; i < 10; i++) send(0, 0, 4'b1001, 4'd0, 16'(16'h100 + 2 * i), 16'(i * 16'h1111));
    chk("t2_full", lsq_full, 1);
    chk("t2_en", mem_enable, 1);
    snap_a = mem_address_out;
    repeat (4) tick();
    chk("t2_stable_addr", mem_address_out, snap_a);
    chk("t2_still_full", lsq_full, 1);
    chk("t2_no_xfer", n_xfer - x0, 0);
    d_ready = 1;
    wait_empty(100);
    chk("t2_drained", n_xfer - x0, 10);
    chk("t2_not_full", lsq_full, 0);
    // outstanding-load bound
    x0 = n_xfer;
    for (int i = 0; i < 6; i++) send(0, 0, 4'b0101, 4'(i), 16'(2 * i), 16'h0);
    repeat (12) tick();
    chk("t3_four", n_xfer - x0, 4);
    d_ack = 1; tick(); d_ack = 0;
    repeat (6) tick();
    chk("t3_five", n_xfer - x0, 5);
    d_ack = 1; tick(); d_ack = 0;
    wait_en();
    d_ack = 1; tick(); d_ack = 0;
    chk("t3_six", n_xfer - x0, 6);
    d_ack = 1; tick(); tick(); d_ack = 0;
    tick();
    chk("t3_one_left", lsu_empty, 0);
    d_ack = 1; tick(); d_ack = 0;
    tick();
    chk("t3_none_left", lsu_empty, 1);
    // fence draining
    d_idle = 0;
    x0 = n_xfer;
    send(0, 0, 4'b0001, 4'd5, 16'h0010, 16'h0);
    send(1, 2'd2, 4'b1001, 4'd0, 16'h0000, 16'h0);
    send(0, 0, 4'b1001, 4'd0, 16'h0020, 16'hA1B2);
    repeat (10) tick();
    chk("t4_only_load", n_xfer - x0, 1);
    chk("t4_fence_held", mem_enable, 0);
    d_ack = 1; d_idle = 1;
    #1;
    chk("t4_wb_mirror", wb_valid, 1);
    tick(); d_ack = 0;
    wait_en();
    chk("t4_fence_mode", mem_mode, 2);
    chk("t4_fence_fnc", mem_fnc_type, 2'b10);
    tick();
    chk("t4_store_en", mem_enable, 1);
    chk("t4_store_mode", mem_mode, 1);
    chk("t4_store_data", mem_data_out, 16'hB2A1);
    wait_empty(50);
    // clock-enable freeze
    d_ready = 0;
    for (int i = 0; i < 3; i++) send(0, 0, 4'b1001, 4'd0, 16'(16'h40 + 2 * i), 16'(16'h5A00 + i));
    repeat (3) tick();
    snap_en = mem_enable; snap_a = mem_address_out; snap_full = lsq_full; snap_empty = lsu_empty;
    d_en = 0;
    for (int i = 0; i < 5; i++) begin
      call = 1; fence_mode = 0; func4_in = 4'b0001; address_in = 16'(i);
      d_ack = i[0]; d_ready = 1;
      #1;
      chk("t6_wb", wb_valid, d_ack);
      tick();
      chk("t6_en", mem_enable, snap_en);
      chk("t6_addr", mem_address_out, snap_a);
      chk("t6_full", lsq_full, snap_full);
      chk("t6_empty", lsu_empty, snap_empty);
    end
    call = 0; d_ack = 0; d_en = 1;
    wait_empty(100);
    // reset mid-drain with loads outstanding
    send(0, 0, 4'b0001, 4'd3, 16'h0080, 16'h0);
    send(0, 0, 4'b0001, 4'd4, 16'h0082, 16'h0);
    repeat (5) tick();
    d_ready = 0;
    for (int i = 0; i < 6; i++) send(0, 0, 4'b1001, 4'd0, 16'(16'h90 + 2 * i), 16'(i));
    tick();
    chk("t5_busy", lsu_empty, 0);
    async_rst = 1;
    #1;
    chk("t5_en", mem_enable, 0);
    chk("t5_full", lsq_full, 0);
    chk("t5_empty", lsu_empty, 1);
    d_idle = 0; #1;
    chk("t5_empty_idle0", lsu_empty, 0);
    d_idle = 1;
    tick(); tick();
    async_rst = 0;
    d_ready = 1;
    tick();
    d_ack = 1; tick(); tick(); d_ack = 0;
    tick();
    chk("t5_stale_ack", lsu_empty, 1);
    // randomized traffic
    rnd_on = 1;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      f = 4'($urandom);
      f[3] = k < 5;
      send(k == 9, 2'($urandom), f, 4'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 4) == 0) tick();
    end
    wait_empty(3000);
    rnd_on = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
